// File: rtl/fir_pkg.sv
// Shared widths, FSM state encoding and output rounding for the FIR MAC controller.
// Output saturation is selected at build time with FIR_SAT_EN (wrap when undefined).
package fir_pkg;

    localparam int SAMPLE_W = 16;
    localparam int COEF_W   = 16;
    localparam int ACC_W    = 38;
    localparam int MAX_TAPS = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Round half up to Q15, then saturate or wrap to 16 bits.
    function automatic logic [SAMPLE_W-1:0] round_out(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] w_shift;
        w_shift = (sum + 38'sd16384) >>> 15;
`ifdef FIR_SAT_EN
        if (w_shift > 38'sd32767) begin
            return 16'h7FFF;
        end
        if (w_shift < -38'sd32768) begin
            return 16'h8000;
        end
`endif
        return 16'(w_shift);
    endfunction

    function automatic logic [5:0] clamp_taps(input logic [5:0] t);
        if (t < 6'd2) begin
            return 6'd2;
        end
        if (t > 6'd32) begin
            return 6'd32;
        end
        return t;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered 16x16 signed multiply followed by a 38-bit accumulator that adds
// the product register one cycle after it was loaded.
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [COEF_W-1:0]   b,
    output logic signed [ACC_W-1:0]    acc
);

    logic signed [SAMPLE_W+COEF_W-1:0] r_prod;
    logic signed [ACC_W-1:0]           r_acc;
    logic                              r_en_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
            r_acc  <= '0;
            r_en_d <= 1'b0;
        end else if (clr) begin
            r_prod <= '0;
            r_acc  <= '0;
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= en;
            if (en) begin
                r_prod <= a * b;
            end
            if (r_en_d) begin
                r_acc <= r_acc + ACC_W'(r_prod);
            end
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR sequencer: ring buffer of samples, coefficient RAM, external loop counter handshake.
// Build option FIR_SAT_EN: saturate out_sample instead of wrapping.
module fir_mac_ctrl
    import fir_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic                wsp_we,
    input  logic [4:0]          wsp_addr,
    input  logic [COEF_W-1:0]   wsp_data,
    input  logic [5:0]          taps,
    input  logic                taps_load,
    output logic                petla_en,
    output logic                reset_petla,
    output logic                zapisz_wsp,
    output logic [5:0]          wsp,
    input  logic [4:0]          adres,
    input  logic                full,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic                busy
);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [4:0]                 r_wp;
    logic [5:0]                 r_taps;
    logic                       r_zapisz;
    logic [SAMPLE_W-1:0]        r_out;
    logic                       r_full_seen;
    logic [4:0]                 r_run_cnt;
    logic signed [SAMPLE_W-1:0] r_ring [MAX_TAPS];
    logic signed [COEF_W-1:0]   r_coef [MAX_TAPS];

    logic                       w_accept;
    logic                       w_timeout;
    logic                       w_mac_en;
    logic [4:0]                 w_ring_idx;
    logic signed [SAMPLE_W-1:0] w_samp;
    logic signed [COEF_W-1:0]   w_coef;
    logic signed [ACC_W-1:0]    w_acc;

    assign w_accept   = (r_state == ST_IDLE) && in_valid;
    assign w_timeout  = (r_run_cnt == 5'd31) && !full;
    // The RUN cycle after full carries no new tap; it only lets the last product land.
    assign w_mac_en   = (r_state == ST_RUN) && !r_full_seen;
    assign w_ring_idx = r_wp - 5'd1 - adres;
    assign w_samp     = r_ring[w_ring_idx];
    assign w_coef     = r_coef[adres];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_next = ST_START;
            ST_START: w_state_next = ST_RUN;
            ST_RUN:   if (r_full_seen || w_timeout) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_OUT;
            ST_OUT:   if (out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wp        <= '0;
            r_taps      <= 6'd2;
            r_zapisz    <= 1'b0;
            r_out       <= '0;
            r_full_seen <= 1'b0;
            r_run_cnt   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_zapisz <= 1'b0;
            if (w_accept) begin
                r_wp <= r_wp + 5'd1;
            end
            if ((r_state == ST_IDLE) && taps_load) begin
                r_taps   <= clamp_taps(taps);
                r_zapisz <= 1'b1;
            end
            case (r_state)
                ST_START: begin
                    r_full_seen <= 1'b0;
                    r_run_cnt   <= '0;
                end
                ST_RUN: begin
                    if (full) r_full_seen <= 1'b1;
                    r_run_cnt <= r_run_cnt + 5'd1;
                end
                ST_DRAIN: r_out <= round_out(w_acc);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                r_ring[i] <= '0;
            end
        end else if (w_accept) begin
            r_ring[r_wp] <= in_sample;
        end
    end

    // Coefficients survive reset so a reset does not force a reload.
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && wsp_we) begin
            r_coef[wsp_addr] <= wsp_data;
        end
    end

    fir_mac_unit u_mac (
        .clk (clk),
        .rst (rst),
        .clr (r_state == ST_START),
        .en  (w_mac_en),
        .a   (w_samp),
        .b   (w_coef),
        .acc (w_acc)
    );

    assign in_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign petla_en    = (r_state == ST_RUN);
    assign reset_petla = (r_state == ST_START);
    assign out_valid   = (r_state == ST_OUT);
    assign zapisz_wsp  = r_zapisz;
    assign wsp         = r_taps;
    assign out_sample  = r_out;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Scoreboard bench for fir_mac_ctrl with a behavioural loop counter model.
module tb_fir_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sample;
    logic        wsp_we;
    logic [4:0]  wsp_addr;
    logic [15:0] wsp_data;
    logic [5:0]  taps;
    logic        taps_load;
    logic        petla_en;
    logic        reset_petla;
    logic        zapisz_wsp;
    logic [5:0]  wsp;
    logic [4:0]  adres_m;
    logic        full_m;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic        busy;

    logic [5:0]  n_m;
    logic        force_nofull;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    int          checks = 0;
    int          errors = 0;

`ifdef FIR_SAT_EN
    localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
    localparam logic [15:0] OVF_EXP = 16'hFFFC;
`endif

    always #5 clk = ~clk;

    fir_mac_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sample   (in_sample),
        .wsp_we      (wsp_we),
        .wsp_addr    (wsp_addr),
        .wsp_data    (wsp_data),
        .taps        (taps),
        .taps_load   (taps_load),
        .petla_en    (petla_en),
        .reset_petla (reset_petla),
        .zapisz_wsp  (zapisz_wsp),
        .wsp         (wsp),
        .adres       (adres_m),
        .full        (full_m),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sample  (out_sample),
        .busy        (busy)
    );

    // External loop counter as seen by the controller.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            adres_m <= '0;
            n_m     <= 6'd2;
        end else begin
            if (reset_petla) adres_m <= '0;
            else if (petla_en) adres_m <= adres_m + 5'd1;
            if (zapisz_wsp) n_m <= wsp;
        end
    end
    assign full_m = !force_nofull && ({1'b0, adres_m} == n_m - 6'd1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h required none", out_sample);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("OUT out_sample=%h expected=%h", out_sample, mon_exp);
                chk("out_sample", 32'(out_sample), 32'(mon_exp));
            end
        end
    end

    task automatic load_taps(input logic [5:0] t, input logic [5:0] expw);
        @(negedge clk); taps = t; taps_load = 1'b1;
        @(negedge clk); taps_load = 1'b0;
        chk("zapisz_pulse", 32'(zapisz_wsp), 1);
        chk("wsp_clamped", 32'(wsp), 32'(expw));
        @(negedge clk);
        chk("zapisz_pulse_end", 32'(zapisz_wsp), 0);
        $display("CFG taps=%0d wsp=%0d", t, wsp);
    endtask

    task automatic wcoef(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk); wsp_we = 1'b1; wsp_addr = a; wsp_data = d;
        @(negedge clk); wsp_we = 1'b0;
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic start_txn(input logic [15:0] s);
        int g = 0;
        @(negedge clk); in_valid = 1'b1; in_sample = s;
        while (!in_ready && g < 100) begin
            @(negedge clk); g++;
        end
        chk("in_ready_wait", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        $display("TXN in_sample=%h", s);
    endtask

    task automatic wait_lat(output int k);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk); k++;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 200) begin
            @(negedge clk); g++;
        end
        chk("idle_wait", 32'(busy), 0);
    endtask

    task automatic run_txn(input logic [15:0] s, input logic [15:0] e, input int lat);
        int k;
        exp_q.push_back(e);
        start_txn(s);
        wait_lat(k);
        chk("latency", k, lat);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int pe;
        int ov;
        rst = 1'b1; in_valid = 1'b0; in_sample = '0; wsp_we = 1'b0; wsp_addr = '0;
        wsp_data = '0; taps = '0; taps_load = 1'b0; out_ready = 1'b1; force_nofull = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_petla_en", 32'(petla_en), 0);
        chk("rst_reset_petla", 32'(reset_petla), 0);
        chk("rst_zapisz", 32'(zapisz_wsp), 0);
        chk("rst_wsp", 32'(wsp), 2);
        chk("rst_out_sample", 32'(out_sample), 0);

        load_taps(6'd40, 6'd32);
        load_taps(6'd1, 6'd2);
        load_taps(6'd4, 6'd4);

        // Impulse response with N=4.
        wcoef(5'd0, 16'h4000);
        wcoef(5'd1, 16'h2000);
        wcoef(5'd2, 16'h1000);
        wcoef(5'd3, 16'h0800);
        run_txn(16'h7FFF, 16'h4000, 7);
        run_txn(16'h0000, 16'h2000, 7);
        run_txn(16'h0000, 16'h1000, 7);
        run_txn(16'h0000, 16'h0800, 7);
        run_txn(16'h0000, 16'h0000, 7);

        // Reset in the third RUN cycle abandons the computation.
        start_txn(16'h1111);
        pe = 0; k = 0;
        while (pe < 3 && k < 50) begin
            @(negedge clk); k++;
            if (petla_en) pe++;
        end
        chk("run_cycles_before_rst", pe, 3);
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", 32'(busy), 0);
        chk("midrun_rst_petla_en", 32'(petla_en), 0);
        chk("midrun_rst_out_valid", 32'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_ready), 1);
        chk("release_wsp", 32'(wsp), 2);
        ov = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        chk("no_output_after_rst", ov, 0);

        // Overflow with N=2 (restored by reset).
        wcoef(5'd0, 16'h7FFF);
        wcoef(5'd1, 16'h7FFF);
        run_txn(16'h7FFF, 16'h7FFE, 5);
        run_txn(16'h7FFF, OVF_EXP, 5);

        // Backpressure: output held, input ignored.
        out_ready = 1'b0;
        exp_q.push_back(16'h7FFE);
        start_txn(16'h0000);
        wait_lat(k);
        chk("bp_latency", k, 5);
        in_valid = 1'b1; in_sample = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_sample", 32'(out_sample), 32'h7FFE);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        run_txn(16'h0000, 16'h0000, 5);

        // N=32 latency and ring addressing across the wrap.
        for (int a = 4; a < 32; a++) wcoef(5'(a), 16'h0000);
        load_taps(6'd32, 6'd32);
        run_txn(16'h0000, 16'h0800, 35);

        // Timeout with full held low; taps_load during RUN is ignored.
        force_nofull = 1'b1;
        exp_q.push_back(16'h0000);
        start_txn(16'h0000);
        k = 0; pe = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk); k++;
            if (taps_load) begin
                taps_load = 1'b0;
                chk("no_zapisz_in_run", 32'(zapisz_wsp), 0);
                chk("wsp_held_in_run", 32'(wsp), 32);
            end
            if (petla_en) begin
                pe++;
                if (pe == 2) begin
                    taps = 6'd7; taps_load = 1'b1;
                end
            end
        end
        chk("timeout_run_cycles", pe, 32);
        chk("timeout_latency", k, 34);
        wait_idle();
        force_nofull = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
